product_accumulator: RTL and testbench
======================================

# product_accumulator

Sequential accumulation stage downstream of the 4-bit combinational multipliers. It takes a programmed-length stream of PSIZE-bit products over a valid/ready handshake and sums them into an ASIZE-bit register. It presents the finished sum on a second valid/ready handshake. It turns the single-product multiplier cores into a dot-product / multiply-accumulate datapath.

## Interface
- PSIZE, 8, product width; matches the 8-bit Result of the 4-bit multiplier cores
- ASIZE, 16, accumulator and Sum width; must be greater than or equal to PSIZE
- COUNT_W, 4, width of Length; maximum job is 2^COUNT_W - 1 products
- Clock  input  1  single clock; all state changes on the rising edge
- Reset  input  1  synchronous, active-high; sampled on the rising edge of Clock
- Start  input  1  begins a job; honoured only in IDLE
- Length  input  COUNT_W  number of products in the job; sampled when Start is accepted
- Product  input  PSIZE  unsigned product from the multiplier
- ProductValid  input  1  Product is valid this cycle
- ProductReady  output  1  block accepts Product this cycle
- Sum  output  ASIZE  accumulated result
- SumValid  output  1  Sum holds a completed job
- SumReady  input  1  consumer takes Sum
- Busy  output  1  high when the state is not IDLE
- Overflow  output  1  sticky flag; set if any add in the current job carried out of ASIZE

## Operation
- States are IDLE, ACCUM and HOLD. Reset forces IDLE.
- IDLE:
  - ProductReady=0, SumValid=0, Busy=0.
  - When Start=1: latch Length, clear the accumulator, clear the count, clear Overflow.
  - If the latched Length=0, go to HOLD with Sum=0. Otherwise go to ACCUM.
- ACCUM:
  - ProductReady=1, Busy=1.
  - A product is accepted when ProductValid=1 and ProductReady=1 in the same cycle.
  - On each accept: accumulator <= accumulator + zero-extended Product, and count <= count + 1.
  - When the accept makes count equal the latched Length, go to HOLD.
  - With ProductValid=0 the state and accumulator hold.
- HOLD:
  - SumValid=1, Busy=1, ProductReady=0.
  - Sum equals the accumulator and stays stable until SumReady=1.
  - When SumReady=1, go to IDLE.
- Start outside IDLE is ignored. Length changes outside the Start cycle have no effect.
- Arithmetic:
  - Unsigned ASIZE+1-bit add.
  - Bit ASIZE of the add result is the carry; the carry sets Overflow.
  - Overflow clears only on an accepted Start or on Reset.
  - Without saturation the sum wraps modulo 2^ASIZE.
- Sum is driven directly from the accumulator register at all times, not gated by SumValid. Its value outside HOLD is undefined for consumers.

## Timing
- Reset values: ProductReady=0, SumValid=0, Busy=0, Overflow=0, Sum=0, count=0, state IDLE.
- Reset asserted in any state returns to IDLE on the next edge. Any partial sum is discarded.
- Start accepted at edge N: Busy=1 and ProductReady=1 from cycle N+1.
  - Exception: with Length=0, SumValid=1 from cycle N+1 instead.
- Throughput is one product per cycle. Producer back-pressure, via ProductValid gaps, is unlimited.
- Last product accepted at edge M: SumValid=1 from cycle M+1, carrying the complete sum. There is one cycle of latency.
- SumReady=1 while SumValid=1 at edge K gives IDLE in cycle K+1. The earliest next Start is accepted at edge K+1.
- SumReady while not in HOLD is ignored.
- ProductReady is a function of state only. There is no combinational path from ProductValid or SumReady to any output.

## Configuration
- Macro: PRODUCT_ACCUMULATOR_SATURATE_EN.
- Defined: an add that carries clamps the accumulator to 2^ASIZE-1. Further adds in the same job hold that value. Overflow is set as normal.
- Undefined: the accumulator wraps modulo 2^ASIZE. Overflow is set as normal.
- The macro changes nothing else: interface, latency and handshake are identical in both builds.

## Test plan
- Basic job: ASIZE=16, Start with Length=3; products 0xE1, 0x31, 0x06 on consecutive cycles -> SumValid one cycle after the third accept, Sum=0x0118, Overflow=0.
- Back-pressure: same job with ProductValid low for 2 cycles between products and SumReady held low 3 cycles -> Sum=0x0118 stable throughout HOLD; IDLE the cycle after SumReady.
- Zero length: Start with Length=0 -> SumValid=1 next cycle with Sum=0; ProductReady never rises.
- Overflow, ASIZE=10, Length=5, five products of 0xE1:
  - Without PRODUCT_ACCUMULATOR_SATURATE_EN -> Sum=0x065, Overflow=1.
  - With PRODUCT_ACCUMULATOR_SATURATE_EN -> Sum=0x3FF, Overflow=1.
- Ignored inputs: Start pulsed during ACCUM and HOLD with a different Length -> job length unchanged; SumReady pulsed during ACCUM -> no effect.
- Reset mid-job: Reset after 2 of 4 products -> next cycle all outputs at reset values. A new Length=1 job with product 0x09 -> Sum=0x0009, Overflow=0.

Source files
------------

// File: rtl/product_accumulator.sv
// Product accumulator: sums a programmed-length stream of products and hands the total off over valid/ready.
// Build option PRODUCT_ACCUMULATOR_SATURATE_EN clamps the accumulator at all-ones instead of wrapping.
module product_accumulator #(
  parameter int PSIZE   = 8,
  parameter int ASIZE   = 16,
  parameter int COUNT_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] length,
  input  logic [PSIZE-1:0]   product,
  input  logic               product_valid,
  output logic               product_ready,
  output logic [ASIZE-1:0]   sum,
  output logic               sum_valid,
  input  logic               sum_ready,
  output logic               busy,
  output logic               overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t             state_reg, state_next;
  logic [ASIZE-1:0]   acc_reg, acc_next;
  logic [COUNT_W-1:0] count_reg, count_next;
  logic [COUNT_W-1:0] len_reg, len_next;
  logic               ovf_reg, ovf_next;

  logic [ASIZE:0]     add_full;
  logic [ASIZE-1:0]   acc_add;
  logic [COUNT_W-1:0] count_inc;

  assign add_full  = {1'b0, acc_reg} + {{(ASIZE+1-PSIZE){1'b0}}, product};
  assign count_inc = count_reg + COUNT_W'(1);

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  // Once clamped, any further non-zero add carries again, so the value sticks at all-ones.
  assign acc_add = add_full[ASIZE] ? {ASIZE{1'b1}} : add_full[ASIZE-1:0];
`else
  assign acc_add = add_full[ASIZE-1:0];
`endif

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    count_next = count_reg;
    len_next   = len_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          len_next   = length;
          acc_next   = '0;
          count_next = '0;
          ovf_next   = 1'b0;
          state_next = (length == '0) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (product_valid) begin
          acc_next   = acc_add;
          count_next = count_inc;
          if (add_full[ASIZE]) ovf_next = 1'b1;
          if (count_inc == len_reg) state_next = HOLD;
        end
      end
      HOLD: begin
        if (sum_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      count_reg <= '0;
      len_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      count_reg <= count_next;
      len_reg   <= len_next;
      ovf_reg   <= ovf_next;
    end
  end

  // Handshake outputs depend on state alone: no combinational input-to-output path.
  assign product_ready = (state_reg == ACCUM);
  assign sum_valid     = (state_reg == HOLD);
  assign busy          = (state_reg != IDLE);
  assign overflow      = ovf_reg;
  assign sum           = acc_reg;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a 16-bit and a 10-bit accumulator share one stimulus stream and
// are checked every cycle against a whole-job arithmetic model plus literal per-job expectations.
module tb_product_accumulator;

  logic       clock = 1'b0;
  logic       reset, start, product_valid, sum_ready;
  logic [3:0] length;
  logic [7:0] product;

  logic        pr16, sv16, busy16, ovf16;
  logic [15:0] sum16;
  logic        pr10, sv10, busy10, ovf10;
  logic [9:0]  sum10;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;
  int prods [8];

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  localparam int OVF_JOB_SUM10 = 'h3FF;
`else
  localparam int OVF_JOB_SUM10 = 'h065;
`endif

  always #5 clock = ~clock;

  product_accumulator #(.PSIZE(8), .ASIZE(16), .COUNT_W(4)) u16 (
    .clock(clock), .reset(reset), .start(start), .length(length),
    .product(product), .product_valid(product_valid), .product_ready(pr16),
    .sum(sum16), .sum_valid(sv16), .sum_ready(sum_ready),
    .busy(busy16), .overflow(ovf16)
  );

  product_accumulator #(.PSIZE(8), .ASIZE(10), .COUNT_W(4)) u10 (
    .clock(clock), .reset(reset), .start(start), .length(length),
    .product(product), .product_valid(product_valid), .product_ready(pr10),
    .sum(sum10), .sum_valid(sv10), .sum_ready(sum_ready),
    .busy(busy10), .overflow(ovf10)
  );

  // Job model: phase 0 = waiting for a job, 1 = collecting products, 2 = result offered.
  // m_sum is the exact mathematical total of the job; width effects are applied on read.
  int phase = 0;
  int m_len = 0;
  int m_cnt = 0;
  int m_sum = 0;

  always @(posedge clock) begin
    if (reset) begin
      phase <= 0;
      m_cnt <= 0;
      m_sum <= 0;
    end else begin
      case (phase)
        0: if (start) begin
          m_len <= int'(length);
          m_cnt <= 0;
          m_sum <= 0;
          phase <= (length == 4'd0) ? 2 : 1;
        end
        1: if (product_valid) begin
          m_sum <= m_sum + int'(product);
          m_cnt <= m_cnt + 1;
          if (m_cnt + 1 == m_len) phase <= 2;
        end
        2: if (sum_ready) phase <= 0;
        default: phase <= 0;
      endcase
    end
  end

  function automatic int exp_sum(input int total, input int asz);
    int lim;
    lim = 1 << asz;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    return (total >= lim) ? lim - 1 : total;
`else
    return total % lim;
`endif
  endfunction

  function automatic int exp_ovf(input int total, input int asz);
    return (total >= (1 << asz)) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_on && !reset) begin
      check("ready16", int'(pr16),   int'(phase == 1));
      check("valid16", int'(sv16),   int'(phase == 2));
      check("busy16",  int'(busy16), int'(phase != 0));
      check("ovf16",   int'(ovf16),  exp_ovf(m_sum, 16));
      check("ready10", int'(pr10),   int'(phase == 1));
      check("valid10", int'(sv10),   int'(phase == 2));
      check("busy10",  int'(busy10), int'(phase != 0));
      check("ovf10",   int'(ovf10),  exp_ovf(m_sum, 10));
      if (phase == 2) begin
        check("sum16", int'(sum16), exp_sum(m_sum, 16));
        check("sum10", int'(sum10), exp_sum(m_sum, 10));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // poke drives Start with another Length and SumReady while the job is running.
  task automatic run_job(input int len, input int n, input int gap, input int hold,
                         input bit poke, input int e16, input int e10, input int eo10);
    int waited;
    start  = 1'b1;
    length = 4'(len);
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat (gap) begin
        product_valid = 1'b0;
        start = poke; length = poke ? 4'd7 : 4'(len); sum_ready = poke;
        step();
      end
      product_valid = 1'b1;
      product = 8'(prods[i]);
      start = poke; length = poke ? 4'd7 : 4'(len); sum_ready = poke;
      step();
    end
    product_valid = 1'b0;
    start = 1'b0;
    sum_ready = 1'b0;
    waited = 0;
    while (!sv16 && waited < 20) begin
      step();
      waited++;
    end
    check("sum_valid_arrives", int'(sv16), 1);
    check("job_sum16", int'(sum16), e16);
    check("job_sum10", int'(sum10), e10);
    check("job_ovf16", int'(ovf16), 0);
    check("job_ovf10", int'(ovf10), eo10);
    $display("job len=%0d gap=%0d hold=%0d poke=%0d sum16=0x%0h sum10=0x%0h ovf10=%0d",
             len, gap, hold, poke, sum16, sum10, ovf10);
    repeat (hold) begin
      start = poke; length = 4'd7;
      step();
      check("hold_sum16", int'(sum16), e16);
    end
    start = 1'b0;
    sum_ready = 1'b1;
    step();
    sum_ready = 1'b0;
    check("idle_after_take", int'(busy16), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; length = '0; product = '0;
    product_valid = 1'b0; sum_ready = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    chk_on = 1'b1;
    check("rst_sum16", int'(sum16), 0);
    check("rst_busy16", int'(busy16), 0);
    check("rst_ready16", int'(pr16), 0);
    check("rst_valid16", int'(sv16), 0);
    check("rst_ovf16", int'(ovf16), 0);

    // Basic job: 0xE1 + 0x31 + 0x06 = 0x118
    prods[0] = 'hE1; prods[1] = 'h31; prods[2] = 'h06;
    run_job(3, 3, 0, 0, 1'b0, 'h118, 'h118, 0);
    // Producer gaps and consumer stall
    run_job(3, 3, 2, 3, 1'b0, 'h118, 'h118, 0);
    // Zero-length job
    run_job(0, 0, 0, 1, 1'b0, 0, 0, 0);
    // 5 x 0xE1 = 0x465: fits 16 bits, overflows 10 bits
    for (int i = 0; i < 5; i++) prods[i] = 'hE1;
    run_job(5, 5, 0, 0, 1'b0, 'h465, OVF_JOB_SUM10, 1);
    // Start/Length/SumReady activity outside IDLE must be ignored
    prods[0] = 'hE1; prods[1] = 'h31; prods[2] = 'h06;
    run_job(3, 3, 1, 2, 1'b1, 'h118, 'h118, 0);

    // Reset after 2 of 4 products discards the partial sum
    start = 1'b1; length = 4'd4;
    step();
    start = 1'b0;
    product_valid = 1'b1; product = 8'h10;
    step();
    product = 8'h20;
    step();
    product_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_sum16", int'(sum16), 0);
    check("midrst_sum10", int'(sum10), 0);
    check("midrst_busy16", int'(busy16), 0);
    check("midrst_ready16", int'(pr16), 0);
    check("midrst_valid16", int'(sv16), 0);
    $display("reset mid-job: sum16=0x%0h busy16=%0d", sum16, busy16);
    prods[0] = 'h09;
    run_job(1, 1, 0, 0, 1'b0, 'h009, 'h009, 0);

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
